// File: rtl/sched_pkg.sv
// Shared definitions for the group scheduler.
//   grp_state_e : per-group state encoding (IDLE / RUN / PEND)
//   MAX_GROUPS  : upper bound on the number of groups a picker can handle
//   rr_first    : round-robin search, returns the first set request at or
//                 after a start pointer, wrapping modulo n
package sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } grp_state_e;

  localparam int MAX_GROUPS = 32;
  localparam int MAX_IW     = 5;

  // Returns 0 when nothing is requested; callers qualify with |req.
  function automatic logic [MAX_IW-1:0] rr_first(
    input logic [MAX_GROUPS-1:0] req,
    input int                    ptr,
    input int                    n
  );
    logic              found;
    logic [MAX_IW-1:0] res;
    int                idx;
    found = 1'b0;
    res   = '0;
    for (int i = 0; i < MAX_GROUPS; i++) begin
      if (i < n && !found) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (req[idx[MAX_IW-1:0]]) begin
          found = 1'b1;
          res   = idx[MAX_IW-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: chooses the first asserted request at or after ptr,
// wrapping modulo N. Purely combinational.
//   req : request vector, one bit per group
//   ptr : search start index
//   idx : selected index (meaningful only when any is high)
//   any : at least one request is asserted
module rr_pick
  import sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [MAX_GROUPS-1:0] req_ext;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    idx            = IW'(rr_first(req_ext, int'(ptr), N));
    any            = |req;
  end

endmodule

// File: rtl/group_scheduler.sv
// Group scheduler: hands weight chunks to idle PE groups in round-robin
// order and returns their completion results, also in round-robin order.
//   clk, reset              : clock, synchronous active-high reset
//   w_valid/w_ready/w_data/w_id : incoming weight chunk handshake
//   grp_start, grp_weight   : one-hot start pulse and registered chunk
//   grp_done, grp_match     : per-group completion pulse and match flag
//   res_valid/res_ready/res_id/res_match : result handshake
//   all_idle                : every group idle and no pending result
//   err                     : sticky flag, set by grp_done on a non-RUN group
module group_scheduler
  import sched_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int groups = 4,
  parameter int num    = 4,
  parameter int IDW    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [num*DWIDTH-1:0] w_data,
  input  logic [IDW-1:0]        w_id,
  output logic [groups-1:0]     grp_start,
  output logic [num*DWIDTH-1:0] grp_weight,
  input  logic [groups-1:0]     grp_done,
  input  logic [groups-1:0]     grp_match,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [IDW-1:0]        res_id,
  output logic                  res_match,
  output logic                  all_idle,
  output logic                  err
);

  localparam int GW = (groups > 1) ? $clog2(groups) : 1;

  grp_state_e        state [groups];
  logic [IDW-1:0]    id_mem [groups];
  logic [groups-1:0] match_mem;

  logic [GW-1:0]     rr_disp;
  logic [GW-1:0]     rr_res;
  logic [GW-1:0]     res_grp;

  logic [groups-1:0] idle_vec;
  logic [groups-1:0] pend_avail;
  logic [GW-1:0]     disp_idx;
  logic [GW-1:0]     load_idx;
  logic              disp_any;
  logic              load_any;
  logic              dispatch;
  logic              consume;
  logic              load_en;

  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] v);
    return (v == GW'(groups - 1)) ? '0 : v + 1'b1;
  endfunction

  // The group already sitting in the output register stays PEND until
  // consumed; mask it so it is not loaded a second time.
  always_comb begin
    for (int g = 0; g < groups; g++) begin
      idle_vec[g]   = (state[g] == ST_IDLE);
      pend_avail[g] = (state[g] == ST_PEND) && !(res_valid && res_grp == GW'(g));
    end
  end

  rr_pick #(.N(groups), .IW(GW)) u_pick_disp (
    .req (idle_vec),
    .ptr (rr_disp),
    .idx (disp_idx),
    .any (disp_any)
  );

  rr_pick #(.N(groups), .IW(GW)) u_pick_res (
    .req (pend_avail),
    .ptr (rr_res),
    .idx (load_idx),
    .any (load_any)
  );

  assign w_ready  = disp_any;
  assign dispatch = w_valid && w_ready;
  assign consume  = res_valid && res_ready;
  assign load_en  = (!res_valid || consume) && load_any;
  assign all_idle = (&idle_vec) && !res_valid;

  // Control state: group states, pointers, start pulse, output register, err.
  // Each group's state is touched by at most one of dispatch (IDLE),
  // done (RUN) or consume (PEND) in a given cycle, so the updates never clash.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int g = 0; g < groups; g++) state[g] <= ST_IDLE;
      rr_disp    <= '0;
      rr_res     <= '0;
      res_grp    <= '0;
      grp_start  <= '0;
      grp_weight <= '0;
      res_valid  <= 1'b0;
      res_id     <= '0;
      res_match  <= 1'b0;
      err        <= 1'b0;
    end else begin
      grp_start <= '0;
      if (dispatch) begin
        state[disp_idx]     <= ST_RUN;
        grp_start[disp_idx] <= 1'b1;
        grp_weight          <= w_data;
        rr_disp             <= wrap_inc(disp_idx);
      end
      for (int g = 0; g < groups; g++) begin
        if (grp_done[g]) begin
          if (state[g] == ST_RUN) state[g] <= ST_PEND;
          else                    err      <= 1'b1;
        end
      end
      if (consume) state[res_grp] <= ST_IDLE;
      if (load_en) begin
        res_valid <= 1'b1;
        res_id    <= id_mem[load_idx];
        res_match <= match_mem[load_idx];
        res_grp   <= load_idx;
        rr_res    <= wrap_inc(load_idx);
      end else if (consume) begin
        res_valid <= 1'b0;
      end
    end
  end

  // Per-group payload storage; qualified by state, so no reset needed.
  always_ff @(posedge clk) begin
    if (dispatch) id_mem[disp_idx] <= w_id;
    for (int g = 0; g < groups; g++) begin
      if (grp_done[g] && state[g] == ST_RUN) match_mem[g] <= grp_match[g];
    end
  end

endmodule

// File: doc/group_scheduler.md
GROUP_SCHEDULER -- requirements
Module: group_scheduler

Interface
REQ-001 Parameter DWIDTH, default 8, character width in bits.
REQ-002 Parameter groups, default 4, number of PE groups scheduled.
REQ-003 Parameter num, default 4, PEs per group; weight chunk is num*DWIDTH bits.
REQ-004 Parameter IDW, default 16, weight identifier width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 w_valid  input  1  weight chunk offered by the weight-cut stage.
REQ-008 w_ready  output  1  scheduler accepts the chunk this cycle.
REQ-009 w_data  input  num*DWIDTH  weight chunk.
REQ-010 w_id  input  IDW  identifier of the chunk.
REQ-011 grp_start  output  groups  one-cycle start pulse, one-hot.
REQ-012 grp_weight  output  num*DWIDTH  registered chunk for the started group; valid while grp_start is non-zero.
REQ-013 grp_done  input  groups  per-group completion pulse.
REQ-014 grp_match  input  groups  per-group match flag; sampled with grp_done.
REQ-015 res_valid  output  1  result available.
REQ-016 res_ready  input  1  result consumer ready.
REQ-017 res_id  output  IDW  identifier of the completed chunk.
REQ-018 res_match  output  1  match flag of the completed chunk.
REQ-019 all_idle  output  1  every group IDLE and res_valid low.
REQ-020 err  output  1  sticky protocol-error flag.

Function
REQ-021 Each group SHALL hold a 2-bit state: IDLE, RUN, PEND.
REQ-022 w_ready SHALL be combinational: high when at least one group is IDLE.
REQ-023 On w_valid && w_ready, the scheduler SHALL select the first IDLE group at or after rr_disp (wrapping modulo groups), store w_id for it, and set the group to RUN.
REQ-024 grp_start[g] and grp_weight SHALL be driven in the cycle after acceptance; rr_disp SHALL advance to g+1 mod groups.
REQ-025 grp_done[g] in RUN SHALL latch grp_match[g] and move g to PEND in the next cycle.
REQ-026 grp_done[g] outside RUN SHALL be ignored and SHALL set err.
REQ-027 When the output register is empty, or is consumed this cycle, it SHALL load from the first PEND group at or after rr_res (wrapping modulo groups).
REQ-028 On load, rr_res SHALL advance to g+1 mod groups.
REQ-029 The group SHALL stay PEND until its result is consumed.
REQ-030 Minimum latency from grp_done to res_valid SHALL be 2 cycles.
REQ-031 res_valid, res_id and res_match SHALL hold stable while res_valid && !res_ready.
REQ-032 On consumption (res_valid && res_ready), the owning group SHALL return to IDLE in the next cycle.
REQ-033 A group SHALL NOT be dispatched in the same cycle it is freed.
REQ-034 Simultaneous grp_done on several groups SHALL be captured independently, with no loss.
REQ-035 Dispatch and result load in the same cycle SHALL both proceed.

Reset
REQ-036 Reset SHALL force all groups IDLE, rr_disp=0, rr_res=0, grp_start=0, grp_weight=0, res_valid=0, res_id=0, res_match=0, and err=0.
REQ-037 Reset mid-operation SHALL abandon in-flight work; grp_done pulses in the first cycle after reset SHALL set err.

Structure
REQ-038 The state encoding (IDLE/RUN/PEND) and a round-robin first-set-from-pointer function SHALL reside in a shared package, sched_pkg.
REQ-039 One sub-module, rr_pick, SHALL implement parameterised round-robin selection; it is instantiated twice (dispatch and result).

Verification
REQ-040 Four w_valid chunks with ids 1,2,3,4 after reset -> grp_start = 0001, 0010, 0100, 1000 on consecutive cycles; w_ready falls after the 4th acceptance.
REQ-041 grp_done=1111 with grp_match=0101 in one cycle, res_ready=1 -> results in order id1 (match 1), id2 (match 0), id3 (match 1), id4 (match 0), one per cycle.
REQ-042 res_ready held 0 for 5 cycles -> res_id and res_match stable throughout; the group stays PEND; w_ready=0 while all groups are busy.
REQ-043 All groups busy, result consumed, w_valid=1 -> the freed group is restarted no earlier than 2 cycles after consumption.
REQ-044 grp_done[2] pulsed while group 2 is IDLE -> err=1 and remains 1 until reset; no res_valid is produced.
REQ-045 Reset asserted with 2 groups RUN -> next cycle all_idle=1, res_valid=0, w_ready=1.
